// File: rtl/shift_sched_pkg.sv
// Shared constants for the barrel-shifter scheduler: shift types,
// FSM state encoding and the per-pass shift limit.
package shift_sched_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam int MAX_PASS = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/shift_sched_if.sv
// Request/response bundle between the two shift requesters, the
// result consumer (master side) and shift_sched (slave side).
interface shift_sched_if;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_type0;
    logic [1:0]  req_type1;
    logic [4:0]  req_amt0;
    logic [4:0]  req_amt1;
    logic [15:0] req_data0;
    logic [15:0] req_data1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_data;

    modport master (
        output req_valid, req_type0, req_type1,
        output req_amt0, req_amt1, req_data0, req_data1,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_type0, req_type1,
        input  req_amt0, req_amt1, req_data0, req_data1,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/shift_sched_barrel.sv
// Combinational 16-bit barrel shifter, 0..15 positions per pass.
module shift_sched_barrel
    import shift_sched_pkg::*;
(
    input  logic [1:0]  typ,
    input  logic [3:0]  amt,
    input  logic [15:0] din,
    output logic [15:0] dout
);

    logic [4:0] inv;

    assign inv = 5'd16 - {1'b0, amt};

    always_comb begin
        dout = din;
        unique case (typ)
            SH_LSL: dout = din << amt;
            SH_LSR: dout = din >> amt;
            SH_ASR: dout = 16'($signed(din) >>> amt);
            SH_ROR: dout = (din >> amt) | (din << inv);
        endcase
    end

endmodule

// File: rtl/shift_sched.sv
// Two-port arbiter and pass sequencer in front of one barrel shifter.
// Define SHIFT_SCHED_RR_EN for round-robin; otherwise port 0 has fixed priority.
module shift_sched #(
    parameter int W        = 16,
    parameter int MAX_PASS = 15
) (
    input logic          clk,
    input logic          rst,
    shift_sched_if.slave bus
);

    import shift_sched_pkg::*;

    state_t       state;
    state_t       state_nx;
    logic [1:0]   typ_q;
    logic [4:0]   rem;
    logic [4:0]   rem_nx;
    logic [3:0]   step;
    logic [W-1:0] data_q;
    logic [W-1:0] acc;
    logic         id_q;
    logic         prio;
    logic         grant;
    logic         accept;
    logic [1:0]   ready;
    logic [1:0]   sel_typ;
    logic [4:0]   sel_amt;
    logic [W-1:0] sel_data;
    logic [W-1:0] b_in;
    logic [W-1:0] b_out;
    logic         busy_pass;

    always_comb begin
        grant = 1'b0;
        unique case (bus.req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = prio;
            default: grant = 1'b0;
        endcase
    end

    always_comb begin
        ready = 2'b00;
        if (state == ST_IDLE && bus.req_valid[grant])
            ready = 2'b01 << grant;
    end

    assign accept   = |ready;
    assign sel_typ  = grant ? bus.req_type1 : bus.req_type0;
    assign sel_amt  = grant ? bus.req_amt1  : bus.req_amt0;
    assign sel_data = grant ? bus.req_data1 : bus.req_data0;

    // Each pass consumes at most MAX_PASS positions of the remaining amount.
    assign step      = (rem > 5'(MAX_PASS)) ? 4'(MAX_PASS) : rem[3:0];
    assign rem_nx    = rem - {1'b0, step};
    assign busy_pass = (state == ST_PASS1) || (state == ST_PASS2);
    assign b_in      = (state == ST_PASS2) ? acc : data_q;

    shift_sched_barrel u_barrel (
        .typ  (typ_q),
        .amt  (step),
        .din  (b_in),
        .dout (b_out)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (accept) state_nx = ST_PASS1;
            ST_PASS1: state_nx = (rem_nx == 5'd0) ? ST_RESP : ST_PASS2;
            ST_PASS2: state_nx = (rem_nx == 5'd0) ? ST_RESP : ST_PASS2;
            ST_RESP:  if (bus.rsp_ready) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            typ_q  <= SH_LSL;
            rem    <= '0;
            data_q <= '0;
            acc    <= '0;
            id_q   <= 1'b0;
        end else if (accept) begin
            typ_q  <= sel_typ;
            rem    <= sel_amt;
            data_q <= sel_data;
            id_q   <= grant;
        end else if (busy_pass) begin
            acc <= b_out;
            rem <= rem_nx;
        end
    end

`ifdef SHIFT_SCHED_RR_EN
    always_ff @(posedge clk) begin
        if (rst)
            prio <= 1'b0;
        else if (accept)
            prio <= ~grant;
    end
`else
    assign prio = 1'b0;
`endif

    assign bus.req_ready = ready;
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_id    = (state == ST_RESP) && id_q;
    assign bus.rsp_data  = (state == ST_RESP) ? acc : '0;

endmodule
